// File: rtl/div_pkg.sv
// Shared types and constants for the shared iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV0_QUOT = {DIV_W{1'b1}};

endpackage

// File: rtl/div_sched_if.sv
// Request/response bundle between two requesters, one consumer and div_sched.
interface div_sched_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_div0;
    logic             busy;

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_remainder, rsp_div0, busy
    );

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_remainder, rsp_div0, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             quo_msb_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Compare in WIDTH+1 bits; rem < dvsr keeps the difference within WIDTH bits.
    always_comb begin
        shifted_s = {rem_i, quo_msb_i};
        diff_s    = shifted_s - {1'b0, dvsr_i};
        if (shifted_s >= {1'b0, dvsr_i}) begin
            rem_o   = diff_s[WIDTH-1:0];
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s[WIDTH-1:0];
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Two-port round-robin front end around an iterative restoring divider;
// one operation in flight, result returned tagged with the requester id.
module div_sched
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    div_sched_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_div0_q, rsp_div0_d;
    logic             busy_q, busy_d;

    logic             grant0_s, grant1_s, accept_s, acc_id_s;
    logic [WIDTH-1:0] acc_dividend_s, acc_divisor_s;
    logic [WIDTH-1:0] step_rem_s, quo_next_s;
    logic             step_bit_s;

    // Round-robin arbiter: on a tie the port that did not win last time goes first.
    always_comb begin
        grant0_s       = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1_s       = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        accept_s       = (state_q == ST_IDLE) && (grant0_s || grant1_s);
        acc_id_s       = grant1_s;
        acc_dividend_s = grant1_s ? bus.req1_dividend : bus.req0_dividend;
        acc_divisor_s  = grant1_s ? bus.req1_divisor  : bus.req0_divisor;
        bus.req0_ready = (state_q == ST_IDLE) && grant0_s;
        bus.req1_ready = (state_q == ST_IDLE) && grant1_s;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[WIDTH-1]),
        .dvsr_i    (dvsr_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_bit_s)
    );

    assign quo_next_s = {quo_q[WIDTH-2:0], step_bit_s};

    // FSM next-state and datapath/response register updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dvsr_d       = dvsr_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_rem_d    = rsp_rem_q;
        rsp_div0_d   = rsp_div0_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    last_grant_d = acc_id_s;
                    id_d         = acc_id_s;
                    dvsr_d       = acc_divisor_s;
                    quo_d        = acc_dividend_s;
                    rem_d        = {WIDTH{1'b0}};
                    cnt_d        = {CNT_W{1'b0}};
                    if (acc_divisor_s == {WIDTH{1'b0}}) begin
                        state_d      = ST_DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_id_d     = acc_id_s;
                        rsp_result_d = {WIDTH{1'b1}};
                        rsp_rem_d    = acc_dividend_s;
                        rsp_div0_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                quo_d = quo_next_s;
                rem_d = step_rem_s;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d      = ST_DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = quo_next_s;
                    rsp_rem_d    = step_rem_s;
                    rsp_div0_d   = 1'b0;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            dvsr_q       <= {WIDTH{1'b0}};
            quo_q        <= {WIDTH{1'b0}};
            rem_q        <= {WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_rem_q    <= {WIDTH{1'b0}};
            rsp_div0_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dvsr_q       <= dvsr_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_rem_q    <= rsp_rem_d;
            rsp_div0_q   <= rsp_div0_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_remainder = rsp_rem_q;
    assign bus.rsp_div0      = rsp_div0_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed scenarios plus random traffic
// compared against plain-arithmetic expectations.
module tb_div_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    logic tb_last = 1'b1;

    div_sched_if #(.WIDTH(8)) bus ();

    div_sched #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic d0);
        if (b == 8'd0) begin
            q = 8'd255; r = a; d0 = 1'b1;
        end else begin
            q = a / b; r = a % b; d0 = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tb_last = 1'b1;
    endtask

    // Presents one request and waits (bounded) for its acceptance edge.
    task automatic issue(input logic port, input logic [7:0] a, input logic [7:0] b,
                         output logic ok, output int waited);
        @(negedge clk);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_dividend = a; bus.req1_divisor = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_dividend = a; bus.req0_divisor = b;
        end
        waited = 0;
        #1;
        while (!(port ? bus.req1_ready : bus.req0_ready) && waited < 40) begin
            @(negedge clk); #1; waited++;
        end
        ok = port ? bus.req1_ready : bus.req0_ready;
        @(posedge clk);
        #1;
        if (port) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        if (ok) tb_last = port;
    endtask

    // Waits (bounded) for rsp_valid, captures it, optionally completes the handshake.
    task automatic wait_rsp(input logic release_it, output logic got, output int lat,
                            output logic id, output logic [7:0] q, output logic [7:0] r,
                            output logic d0);
        lat = 0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk); lat++;
        end
        got = bus.rsp_valid; id = bus.rsp_id; q = bus.rsp_result;
        r = bus.rsp_remainder; d0 = bus.rsp_div0;
        if (release_it) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder, bus.rsp_div0,
             bus.busy, bus.req0_ready, bus.req1_ready} !== 23'd0)
            $display("FAIL reset_outputs: got v%b id%b q%0d r%0d d0%b busy%b rdy%b%b expected all zero",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder,
                     bus.rsp_div0, bus.busy, bus.req0_ready, bus.req1_ready);
        else passed++;
    endtask

    // Runs a list of single-port operations back to back and checks each result.
    task automatic test_single();
        logic [7:0] ta [6] = '{8'd73, 8'd15, 8'd47, 8'd255, 8'd5, 8'd0};
        logic [7:0] tb [6] = '{8'd12, 8'd3, 8'd7, 8'd1, 8'd9, 8'd7};
        logic ok, got, id, d0, ed0;
        logic [7:0] q, r, eq, er;
        int waited, lat;
        for (int i = 0; i < 6; i++) begin
            model(ta[i], tb[i], eq, er, ed0);
            issue(1'b0, ta[i], tb[i], ok, waited);
            total++;
            if (!ok || waited != 0) $display("FAIL single_accept%0d: got ok=%b wait=%0d expected ok=1 wait=0", i, ok, waited);
            else passed++;
            wait_rsp(1'b1, got, lat, id, q, r, d0);
            total++;
            if (!got || lat != 8) $display("FAIL single_latency%0d: got valid=%b lat=%0d expected valid=1 lat=8", i, got, lat);
            else passed++;
            total++;
            if ({id, q, r, d0} !== {1'b0, eq, er, ed0})
                $display("FAIL single_result%0d %0d/%0d: got id%b q%0d r%0d d0%b expected id0 q%0d r%0d d0%b",
                         i, ta[i], tb[i], id, q, r, d0, eq, er, ed0);
            else passed++;
        end
    endtask

    task automatic test_div0();
        logic ok, got, id, d0;
        logic [7:0] q, r;
        int waited, lat;
        issue(1'b1, 8'd200, 8'd0, ok, waited);
        total++;
        if (!ok) $display("FAIL div0_accept: got ok=%b expected 1", ok); else passed++;
        wait_rsp(1'b1, got, lat, id, q, r, d0);
        total++;
        if (!got || lat != 0) $display("FAIL div0_latency: got valid=%b lat=%0d expected valid=1 lat=0", got, lat);
        else passed++;
        total++;
        if ({id, q, r, d0} !== {1'b1, 8'd255, 8'd200, 1'b1})
            $display("FAIL div0_result: got id%b q%0d r%0d d0%b expected id1 q255 r200 d01", id, q, r, d0);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [7:0] q, r;
        logic exp_id;
        int n, k;
        apply_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_dividend = 8'd100; bus.req0_divisor = 8'd10;
        bus.req1_valid = 1'b1; bus.req1_dividend = 8'd9;   bus.req1_divisor = 8'd4;
        for (int i = 0; i < 4; i++) begin
            exp_id = ~tb_last;
            n = 0;
            #1;
            while (!(bus.req0_ready || bus.req1_ready) && n < 40) begin
                @(negedge clk); #1; n++;
            end
            total++;
            if ({bus.req1_ready, bus.req0_ready} !== (exp_id ? 2'b10 : 2'b01))
                $display("FAIL rr_grant%0d: got ready1/0=%b%b expected winner %0d", i, bus.req1_ready, bus.req0_ready, exp_id);
            else passed++;
            @(posedge clk);
            tb_last = exp_id;
            k = 0;
            @(negedge clk);
            while (!bus.rsp_valid && k < 40) begin
                total++;
                if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
                    $display("FAIL rr_wait_ready%0d: got %b%b expected 00", i, bus.req1_ready, bus.req0_ready);
                else passed++;
                @(negedge clk); k++;
            end
            q = exp_id ? 8'd2 : 8'd10;
            r = exp_id ? 8'd1 : 8'd0;
            total++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder} !== {1'b1, exp_id, q, r})
                $display("FAIL rr_result%0d: got v%b id%b q%0d r%0d expected v1 id%0d q%0d r%0d",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder, exp_id, q, r);
            else passed++;
            total++;
            if (exp_id !== logic'(i % 2)) $display("FAIL rr_order%0d: got winner %0d expected %0d", i, exp_id, i % 2);
            else passed++;
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic ok, got, id, d0, winner;
        logic [7:0] q, r;
        int waited, lat;
        issue(1'b0, 8'd50, 8'd7, ok, waited);
        wait_rsp(1'b0, got, lat, id, q, r, d0);
        bus.req0_valid = 1'b1; bus.req0_dividend = 8'd30; bus.req0_divisor = 8'd4;
        bus.req1_valid = 1'b1; bus.req1_dividend = 8'd90; bus.req1_divisor = 8'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder, bus.rsp_div0,
                 bus.req0_ready, bus.req1_ready, bus.busy} !== {1'b1, 1'b0, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1})
                $display("FAIL bp_hold%0d: got v%b id%b q%0d r%0d d0%b rdy%b%b busy%b expected v1 id0 q7 r1 d00 rdy00 busy1",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder, bus.rsp_div0,
                         bus.req0_ready, bus.req1_ready, bus.busy);
            else passed++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        winner = ~tb_last;
        @(negedge clk);
        #1;
        total++;
        if ({bus.busy, bus.req1_ready, bus.req0_ready} !== {1'b0, winner, ~winner})
            $display("FAIL bp_release: got busy%b rdy1/0=%b%b expected busy0 winner %0d",
                     bus.busy, bus.req1_ready, bus.req0_ready, winner);
        else passed++;
        @(posedge clk);
        #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tb_last = winner;
        wait_rsp(1'b1, got, lat, id, q, r, d0);
        total++;
        if ({got, id, q, r} !== {1'b1, winner, winner ? 8'd10 : 8'd7, winner ? 8'd0 : 8'd2})
            $display("FAIL bp_next_result: got v%b id%b q%0d r%0d expected winner %0d", got, id, q, r, winner);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic ok, got, id, d0;
        logic [7:0] q, r;
        int waited, lat, seen;
        apply_reset();
        issue(1'b0, 8'd73, 8'd12, ok, waited);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tb_last = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder, bus.rsp_div0,
             bus.busy, bus.req0_ready, bus.req1_ready} !== 23'd0)
            $display("FAIL midreset_outputs: got v%b id%b q%0d r%0d d0%b busy%b expected all zero",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_remainder, bus.rsp_div0, bus.busy);
        else passed++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL midreset_no_rsp: got %0d valid cycles expected 0", seen); else passed++;
        issue(1'b0, 8'd73, 8'd12, ok, waited);
        wait_rsp(1'b1, got, lat, id, q, r, d0);
        total++;
        if ({got, id, q, r, d0} !== {1'b1, 1'b0, 8'd6, 8'd1, 1'b0} || lat != 8)
            $display("FAIL midreset_after: got v%b id%b q%0d r%0d d0%b lat%0d expected v1 id0 q6 r1 d00 lat8",
                     got, id, q, r, d0, lat);
        else passed++;
    endtask

    task automatic test_random();
        logic ok, got, id, d0, ed0, port;
        logic [7:0] a, b, q, r, eq, er;
        int waited, lat;
        for (int i = 0; i < 24; i++) begin
            port = logic'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            model(a, b, eq, er, ed0);
            issue(port, a, b, ok, waited);
            wait_rsp(1'b1, got, lat, id, q, r, d0);
            total++;
            if ({ok, got, id, q, r, d0} !== {1'b1, 1'b1, port, eq, er, ed0} || lat != (ed0 ? 0 : 8))
                $display("FAIL random%0d %0d/%0d port%0d: got v%b id%b q%0d r%0d d0%b lat%0d expected q%0d r%0d d0%b",
                         i, a, b, port, got, id, q, r, d0, lat, eq, er, ed0);
            else passed++;
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_dividend = 8'd0; bus.req0_divisor = 8'd0;
        bus.req1_valid = 1'b0; bus.req1_dividend = 8'd0; bus.req1_divisor = 8'd0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_single();
        test_div0();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
